afpm_rr_arbiter: RTL and testbench

AFPM_RR_ARBITER -- requirements
Module: afpm_rr_arbiter

---
 rtl/afpm_rr_arbiter_if.sv | 34 +++
 rtl/afpm_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_afpm_rr_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/afpm_rr_arbiter_if.sv
// Request/multiplier/response bundle shared by the FP16 multiplier arbiter and its users.
// slave is the arbiter's view; master is the requester/multiplier side.
interface afpm_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_done;
  logic [W-1:0]      mul_result;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              busy;
  logic [IW-1:0]     grant_id;

  modport slave (
    input  req_valid, req_a, req_b, mul_done, mul_result, rsp_ready,
    output req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_data, rsp_err, busy, grant_id
  );

  modport master (
    output req_valid, req_a, req_b, mul_done, mul_result, rsp_ready,
    input  req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_data, rsp_err, busy, grant_id
  );
endinterface

// File: rtl/afpm_rr_arbiter.sv
// Round-robin arbiter sharing one FP16 multiplier; one op in flight, accept->rsp_valid min 3 cycles.
// Holds the response until the grantee's rsp_ready; a silent multiplier is aborted with a qNaN error.
module afpm_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst_n,
  afpm_rr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [W-1:0] QNAN = W'(16'h7E00);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q;
  logic [IW-1:0] last_grant_q;
  logic [IW-1:0] grant_id_q;
  logic [CW-1:0] cnt_q;
  logic          mul_start_q;
  logic [W-1:0]  mul_a_q;
  logic [W-1:0]  mul_b_q;
  logic          rsp_valid_q;
  logic [W-1:0]  rsp_data_q;
  logic          rsp_err_q;

  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic [NREQ-1:0] req_ready_d;
  logic [NREQ-1:0] rsp_valid_d;

  // Walk downward so the last hit is the first set bit above last_grant (wrapping).
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req_valid[(int'(last_grant_q) + k) % NREQ]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(last_grant_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready_d = '0;
    if (state_q == IDLE && win_vld) req_ready_d[win_idx] = 1'b1;
  end

  always_comb begin
    rsp_valid_d = '0;
    if (rsp_valid_q) rsp_valid_d[grant_id_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NREQ - 1);
      grant_id_q   <= '0;
      cnt_q        <= '0;
      mul_start_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            mul_a_q     <= bus.req_a[win_idx*W +: W];
            mul_b_q     <= bus.req_b[win_idx*W +: W];
            grant_id_q  <= win_idx;
            mul_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A completion in the final count cycle still wins over the abort.
          if (bus.mul_done) begin
            rsp_data_q  <= bus.mul_result;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_data_q  <= QNAN;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready[grant_id_q]) begin
            last_grant_q <= grant_id_q;
            rsp_valid_q  <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_d;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_d;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.grant_id  = grant_id_q;
endmodule

// File: tb/tb_afpm_rr_arbiter.sv
// Bench for afpm_rr_arbiter: table of operations scored through an expected-response queue,
// plus hand-written reset, reset-during-WAIT and stale-done sequences.
module tb_afpm_rr_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  afpm_rr_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  afpm_rr_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  rv;
    int          dly;   // cycles after mul_start before mul_done; -1 = never
    logic [15:0] res;
    int          grant;
    logic [15:0] data;
    logic        err;
    int          lat;   // cycle of rsp_valid, accept cycle = 0
    int          bp;    // cycles rsp_ready held off
  } vec_t;

  typedef struct {
    int          grant;
    logic [15:0] data;
    logic        err;
    int          lat;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic run_op(input vec_t v);
    exp_t e;
    int   c;
    logic [3:0] oh;
    logic [3:0] nxt;
    oh = 4'b0001 << v.grant;
    @(negedge clk);
    bus.req_valid = v.rv;
    #1;
    chk("req_ready_accept", bus.req_ready, oh);
    chk("busy_idle", bus.busy, 0);
    e.grant = v.grant; e.data = v.data; e.err = v.err; e.lat = v.lat;
    sb.push_back(e);
    @(negedge clk);
    chk("req_ready_issue", bus.req_ready, 0);
    chk("mul_start", bus.mul_start, 1);
    chk("grant_id", bus.grant_id, v.grant);
    chk("mul_a", bus.mul_a, 16'h3C00 + v.grant);
    chk("mul_b", bus.mul_b, 16'h4000 + v.grant);
    bus.req_valid = '0;
    c = 1;
    while (c < 200) begin
      @(negedge clk);
      c++;
      bus.mul_done = 1'b0;
      if (c == 2) chk("mul_start_pulse", bus.mul_start, 0);
      if (bus.rsp_valid != 0) break;
      if (v.dly >= 0 && c == 2 + v.dly) begin
        bus.mul_done   = 1'b1;
        bus.mul_result = v.res;
      end
    end
    chk("rsp_seen", {31'b0, bus.rsp_valid != 0}, 1);
    e = sb.pop_front();
    oh = 4'b0001 << e.grant;
    chk("rsp_valid", bus.rsp_valid, oh);
    chk("rsp_data", bus.rsp_data, e.data);
    chk("rsp_err", bus.rsp_err, e.err);
    chk("latency", c, e.lat);
    for (int b = 0; b < v.bp; b++) begin
      bus.rsp_ready  = ~oh;
      bus.req_valid  = 4'hF;
      bus.mul_done   = b[0];
      bus.mul_result = 16'hBEEF;
      @(negedge clk);
      chk("bp_rsp_data", bus.rsp_data, e.data);
      chk("bp_rsp_valid", bus.rsp_valid, oh);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_busy", bus.busy, 1);
    end
    bus.mul_done  = 1'b0;
    bus.req_valid = 4'hF;
    bus.rsp_ready = oh;
    @(negedge clk);
    bus.rsp_ready = '0;
    nxt = 4'b0001 << ((e.grant + 1) % 4);
    chk("exit_no_accept", bus.busy, 0);
    chk("exit_rsp_clear", bus.rsp_valid, 0);
    chk("rotate_next", bus.req_ready, nxt);
    bus.req_valid = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{4'hF,  0, 16'h4400, 0, 16'h4400, 1'b0,  3,  0};
    vecs[1]  = '{4'hF,  1, 16'h4500, 1, 16'h4500, 1'b0,  4,  0};
    vecs[2]  = '{4'hF,  2, 16'h4600, 2, 16'h4600, 1'b0,  5,  0};
    vecs[3]  = '{4'hF,  0, 16'h4700, 3, 16'h4700, 1'b0,  3,  0};
    vecs[4]  = '{4'hF,  3, 16'h4800, 0, 16'h4800, 1'b0,  6,  0};
    vecs[5]  = '{4'h1,  0, 16'h4000, 0, 16'h4000, 1'b0,  3,  0};
    vecs[6]  = '{4'h4,  0, 16'h3E00, 2, 16'h3E00, 1'b0,  3, 10};
    vecs[7]  = '{4'h3,  0, 16'h4100, 0, 16'h4100, 1'b0,  3,  0};
    vecs[8]  = '{4'h3,  1, 16'h4200, 1, 16'h4200, 1'b0,  4,  0};
    vecs[9]  = '{4'h8, -1, 16'h4300, 3, 16'h7E00, 1'b1, 66, 10};
    vecs[10] = '{4'h8,  0, 16'h4900, 3, 16'h4900, 1'b0,  3,  0};
    vecs[11] = '{4'h2, 63, 16'h5000, 1, 16'h5000, 1'b0, 66,  0};
    vecs[12] = '{4'hF,  0, 16'h5100, 0, 16'h5100, 1'b0,  3,  0};

    bus.req_valid  = '0;
    bus.rsp_ready  = '0;
    bus.mul_done   = 1'b0;
    bus.mul_result = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*W +: W] = 16'h3C00 + 16'(i);
      bus.req_b[i*W +: W] = 16'h4000 + 16'(i);
    end

    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_mul_start", bus.mul_start, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_req_ready_none", bus.req_ready, 0);
    bus.req_valid = 4'hA;
    #1;
    chk("rst_prio_from_0", bus.req_ready, 4'h2);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // Reset while WAITing, then a stale completion after release.
    @(negedge clk);
    bus.req_valid = 4'h4;
    #1;
    chk("pre_rst_accept", bus.req_ready, 4'h4);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_mul_a", bus.mul_a, 0);
    chk("mid_rst_grant", bus.grant_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mul_done   = 1'b1;
    bus.mul_result = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.mul_done = 1'b0;
      chk("stale_rsp_valid", bus.rsp_valid, 0);
      chk("stale_busy", bus.busy, 0);
    end
    run_op(vecs[12]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
